fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of program_counter and the register file decode path.
- Reads the current PC from program_counter and drives its write/inc controls.
- Issues word reads to instruction memory with a req/ack handshake and latches each returned instruction with its PC.
- Presents the instruction to decode with a valid/stall handshake; handles branch redirects and misaligned-target faults.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and branch target
MEM_ADDR_WIDTH, 30, word-address width presented to memory (PC[31:2])

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc_read_data  in  32  current PC from program_counter
pc_inc  out  1  PC += 4 at next edge (combinational)
pc_write  out  1  load pc_write_data into PC at next edge (combinational)
pc_write_data  out  32  branch target forwarded to PC
mem_req  out  1  instruction read request
mem_addr  out  30  word address, equal to pc_read_data[31:2]
mem_ack  in  1  read data valid this cycle
mem_rdata  in  32  instruction word from memory
branch_valid  in  1  redirect request from execute, single cycle
branch_target  in  32  redirect byte address
stall  in  1  decode cannot accept this cycle
instr_valid  out  1  instr/instr_pc hold a valid fetched instruction
instr  out  32  fetched instruction word
instr_pc  out  32  byte address instr was fetched from
fault  out  1  sticky misaligned-branch fault

Behaviour:
- Reset (async, active-high): state IDLE; instr_valid, instr, instr_pc, fault, mem_req all 0. pc_inc and pc_write are 0 while reset is high.
- States: IDLE, REQ, HOLD, FAULT.
- IDLE: one cycle after reset deasserts, then REQ.
- REQ: mem_req=1, mem_addr=pc_read_data[31:2]. Address must stay stable until ack.
  - On mem_ack, same cycle: pc_inc=1.
  - At that edge: instr<=mem_rdata, instr_pc<=pc_read_data, instr_valid<=1, state->HOLD.
  - Latency from request to instr_valid is ack cycle + 1 edge; minimum 1 cycle with a zero-wait ack.
- HOLD: mem_req=0; instr, instr_pc and instr_valid stay stable.
  - stall=1: remain in HOLD.
  - stall=0: instruction is consumed; next edge instr_valid<=0, state->REQ.
- Throughput is at most one instruction per two cycles. No prefetch buffer.
- mem_ack outside REQ is ignored.
- Branch (branch_valid=1 in IDLE, REQ or HOLD), aligned target (branch_target[1:0]==0):
  - Same cycle: pc_write=1, pc_write_data=branch_target, pc_inc=0. Branch beats ack: a simultaneous ack is discarded and nothing is latched.
  - Next edge: instr_valid<=0, state->REQ. The squashed instruction is never presented after the branch cycle.
  - Any outstanding request is abandoned: mem_req may drop with no ack, and memory must tolerate this.
- Branch with misaligned target (branch_target[1:0]!=0):
  - pc_write=0, pc_inc=0.
  - Next edge: fault<=1, instr_valid<=0, state->FAULT.
- FAULT: mem_req=0, pc_inc=0, pc_write=0; branch_valid and mem_ack are ignored. Only reset exits.
- pc_inc and pc_write are never both 1.
- PC wrap: 0xFFFFFFFC + 4 wraps to 0 inside program_counter; no special handling here.
- Reset mid-request or mid-hold: immediate return to the reset state; no PC control pulse is generated.

Test Plan:
- Reset sequence: reset high with PC=0 -> instr_valid=0, mem_req=0, fault=0. Release reset -> mem_req=1 with mem_addr=0 on the second cycle after release.
- Straight-line fetch: ack with mem_rdata=0x11111111, then 0x22222222, stall=0 -> instr/instr_pc pairs 0x11111111/0x0 then 0x22222222/0x4; PC=0x8; exactly one pc_inc per ack.
- Wait states and stall: ack delayed 3 cycles -> mem_addr stable throughout. Then stall=1 for 4 cycles -> instr 0xdeadbeef held valid, mem_req=0, PC unchanged at +4.
- Branch during HOLD: instr valid at PC 0x4, branch_valid with target 0x100 -> pc_write=1, pc_inc=0. Next cycle instr_valid=0 and mem_addr=0x40; following instr_pc=0x100.
- Branch coincident with mem_ack: target 0x200 -> no pc_inc, returned data discarded. PC=0x200; next valid instr_pc=0x200.
- Misaligned branch: target 0x102 -> no pc_write, fault=1 next cycle, mem_req stays 0 despite further branches. Reset clears fault.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles every non-clock/reset signal of the fetch stage.
//   PC side     : pc_read_data (in), pc_inc, pc_write, pc_write_data (out)
//   Memory side : mem_req, mem_addr (out), mem_ack, mem_rdata (in)
//   Execute side: branch_valid, branch_target (in)
//   Decode side : stall (in), instr_valid, instr, instr_pc, fault (out)
// Modport master is the fetch unit itself; slave is its surroundings.
interface fetch_unit_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 30
);
    logic [DATA_WIDTH-1:0]     pc_read_data;
    logic                      pc_inc;
    logic                      pc_write;
    logic [DATA_WIDTH-1:0]     pc_write_data;
    logic                      mem_req;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_ack;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      branch_valid;
    logic [DATA_WIDTH-1:0]     branch_target;
    logic                      stall;
    logic                      instr_valid;
    logic [DATA_WIDTH-1:0]     instr;
    logic [DATA_WIDTH-1:0]     instr_pc;
    logic                      fault;

    modport master (
        input  pc_read_data, mem_ack, mem_rdata, branch_valid, branch_target, stall,
        output pc_inc, pc_write, pc_write_data, mem_req, mem_addr,
               instr_valid, instr, instr_pc, fault
    );

    modport slave (
        output pc_read_data, mem_ack, mem_rdata, branch_valid, branch_target, stall,
        input  pc_inc, pc_write, pc_write_data, mem_req, mem_addr,
               instr_valid, instr, instr_pc, fault
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
//   clock : rising-edge system clock
//   reset : asynchronous, active-high reset
//   bus   : fetch_unit_if.master (PC control, memory req/ack, branch, decode)
// One word is requested at the current PC, latched with its PC on ack and
// held for decode until accepted (stall low). Branches redirect the PC and
// squash anything in flight; a misaligned branch target parks the unit in a
// sticky FAULT state that only reset leaves.
module fetch_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 30
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                state_q;
    logic                  mem_req_q;
    logic                  instr_valid_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] instr_pc_q;
    logic                  fault_q;

    logic                  branch_ok_s;
    logic                  branch_bad_s;
    logic                  pc_inc_s;
    logic                  pc_write_s;

    assign branch_ok_s  = bus.branch_valid && (bus.branch_target[1:0] == 2'b00);
    assign branch_bad_s = bus.branch_valid && (bus.branch_target[1:0] != 2'b00);

    // PC control strobes: a branch always wins over an ack so the two are exclusive.
    always_comb begin
        pc_inc_s   = 1'b0;
        pc_write_s = 1'b0;
        if (reset) begin
            pc_inc_s   = 1'b0;
            pc_write_s = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_write_s = branch_ok_s;
                end
                REQ: begin
                    pc_write_s = branch_ok_s;
                    pc_inc_s   = bus.mem_ack && !bus.branch_valid;
                end
                HOLD: begin
                    pc_write_s = branch_ok_s;
                end
                FAULT: begin
                    pc_inc_s   = 1'b0;
                    pc_write_s = 1'b0;
                end
                default: begin
                    pc_inc_s   = 1'b0;
                    pc_write_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM with its registered decode/memory outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (branch_bad_s) begin
                        state_q   <= FAULT;
                        fault_q   <= 1'b1;
                        mem_req_q <= 1'b0;
                    end else begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (branch_bad_s) begin
                        state_q       <= FAULT;
                        fault_q       <= 1'b1;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b0;
                    end else if (branch_ok_s) begin
                        // Abandon the current request and restart at the new PC.
                        state_q       <= REQ;
                        mem_req_q     <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end else if (bus.mem_ack) begin
                        state_q       <= HOLD;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                        instr_q       <= bus.mem_rdata;
                        instr_pc_q    <= bus.pc_read_data;
                    end else begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_bad_s) begin
                        state_q       <= FAULT;
                        fault_q       <= 1'b1;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b0;
                    end else if (branch_ok_s || !bus.stall) begin
                        // Held word is either squashed or consumed this cycle.
                        state_q       <= REQ;
                        mem_req_q     <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                FAULT: begin
                    state_q       <= FAULT;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    fault_q       <= 1'b1;
                end
                default: begin
                    state_q       <= IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_inc        = pc_inc_s;
    assign bus.pc_write      = pc_write_s;
    assign bus.pc_write_data = bus.branch_target;
    assign bus.mem_req       = mem_req_q;
    // Word address tracks the PC; the PC only moves on ack/branch, so it is stable while waiting.
    assign bus.mem_addr      = bus.pc_read_data[DATA_WIDTH-1:2];
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr         = instr_q;
    assign bus.instr_pc      = instr_pc_q;
    assign bus.fault         = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: abstract view of the stage plus the program counter it drives.
    bit          m_started;  // first post-reset cycle has passed
    bit          m_valid;    // an instruction is held for decode
    bit          m_fault;    // sticky misaligned-branch fault
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] pc;         // program_counter contents

    bit e_mem_req, e_pc_inc, e_pc_write;

    task automatic model_reset();
        m_started = 1'b0;
        m_valid   = 1'b0;
        m_fault   = 1'b0;
        m_instr   = 32'h0;
        m_ipc     = 32'h0;
        pc        = 32'h0;
    endtask

    // Drive one cycle's inputs and compute what the stage should show this cycle.
    task automatic apply(input bit bv, input logic [31:0] tgt, input bit ack,
                         input logic [31:0] rd, input bit stl);
        bus.branch_valid  = bv;
        bus.branch_target = tgt;
        bus.mem_ack       = ack;
        bus.mem_rdata     = rd;
        bus.stall         = stl;
        if (reset) model_reset();
        bus.pc_read_data = pc;
        e_mem_req  = !reset && m_started && !m_valid && !m_fault;
        e_pc_write = !reset && !m_fault && bv && (tgt[1:0] == 2'b00);
        e_pc_inc   = e_mem_req && ack && !bv;
        #1;
    endtask

    // Advance one clock and move the model by the fetch rules.
    task automatic tick();
        @(posedge clock);
        #1;
        if (reset) begin
            model_reset();
        end else if (!m_fault) begin
            if (bus.branch_valid) begin
                m_valid   = 1'b0;
                m_started = 1'b1;
                if (bus.branch_target[1:0] != 2'b00) m_fault = 1'b1;
            end else if (!m_started) begin
                m_started = 1'b1;
            end else if (!m_valid && bus.mem_ack) begin
                m_valid = 1'b1;
                m_instr = bus.mem_rdata;
                m_ipc   = pc;
            end else if (m_valid && !bus.stall) begin
                m_valid = 1'b0;
            end
        end
        if (e_pc_write)    pc = bus.branch_target;
        else if (e_pc_inc) pc = pc + 32'd4;
        bus.pc_read_data = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(1'b1, 32'h40, 1'b1, 32'h55, 1'b0);
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", bus.fault); end
        n_vec++; if (bus.pc_write !== 1'b0) begin n_err++; $display("FAIL reset_pc_write got %b want 0", bus.pc_write); end
        n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL reset_pc_inc got %b want 0", bus.pc_inc); end
        tick();
        reset = 1'b0;
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL idle_mem_req got %b want 0", bus.mem_req); end
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", bus.mem_req); end
        n_vec++; if (bus.mem_addr !== 30'h0) begin n_err++; $display("FAIL first_addr got %h want 0", bus.mem_addr); end
    endtask

    task automatic test_straight_line();
        apply(1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0);
        n_vec++; if (bus.pc_inc !== 1'b1) begin n_err++; $display("FAIL sl_inc1 got %b want 1", bus.pc_inc); end
        n_vec++; if (bus.pc_write !== 1'b0) begin n_err++; $display("FAIL sl_write1 got %b want 0", bus.pc_write); end
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL sl_valid1 got %b want 1", bus.instr_valid); end
        n_vec++; if (bus.instr !== 32'h11111111) begin n_err++; $display("FAIL sl_instr1 got %h want 11111111", bus.instr); end
        n_vec++; if (bus.instr_pc !== 32'h0) begin n_err++; $display("FAIL sl_pc1 got %h want 0", bus.instr_pc); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL sl_hold_req got %b want 0", bus.mem_req); end
        n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL sl_hold_inc got %b want 0", bus.pc_inc); end
        tick();
        apply(1'b0, 32'h0, 1'b1, 32'h22222222, 1'b0);
        n_vec++; if (bus.mem_addr !== 30'h1) begin n_err++; $display("FAIL sl_addr2 got %h want 1", bus.mem_addr); end
        n_vec++; if (bus.pc_inc !== 1'b1) begin n_err++; $display("FAIL sl_inc2 got %b want 1", bus.pc_inc); end
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.instr !== 32'h22222222) begin n_err++; $display("FAIL sl_instr2 got %h want 22222222", bus.instr); end
        n_vec++; if (bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL sl_pc2 got %h want 4", bus.instr_pc); end
        tick();
    endtask

    task automatic test_wait_stall();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL ws_req[%0d] got %b want 1", k, bus.mem_req); end
            n_vec++; if (bus.mem_addr !== 30'h2) begin n_err++; $display("FAIL ws_addr[%0d] got %h want 2", k, bus.mem_addr); end
            n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL ws_inc[%0d] got %b want 0", k, bus.pc_inc); end
            tick();
        end
        apply(1'b0, 32'h0, 1'b1, 32'hdeadbeef, 1'b0);
        n_vec++; if (bus.mem_addr !== 30'h2) begin n_err++; $display("FAIL ws_ack_addr got %h want 2", bus.mem_addr); end
        n_vec++; if (bus.pc_inc !== 1'b1) begin n_err++; $display("FAIL ws_ack_inc got %b want 1", bus.pc_inc); end
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
            n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL st_valid[%0d] got %b want 1", k, bus.instr_valid); end
            n_vec++; if (bus.instr !== 32'hdeadbeef) begin n_err++; $display("FAIL st_instr[%0d] got %h want deadbeef", k, bus.instr); end
            n_vec++; if (bus.instr_pc !== 32'h8) begin n_err++; $display("FAIL st_pc[%0d] got %h want 8", k, bus.instr_pc); end
            n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL st_req[%0d] got %b want 0", k, bus.mem_req); end
            n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL st_inc[%0d] got %b want 0", k, bus.pc_inc); end
            tick();
        end
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL st_release got %b want 1", bus.instr_valid); end
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.mem_addr !== 30'h3) begin n_err++; $display("FAIL st_next_addr got %h want 3", bus.mem_addr); end
    endtask

    task automatic test_branch_hold();
        apply(1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.pc_write !== 1'b1) begin n_err++; $display("FAIL bh_seed_write got %b want 1", bus.pc_write); end
        tick();
        apply(1'b0, 32'h0, 1'b1, 32'ha5a5a5a5, 1'b0);
        tick();
        apply(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        n_vec++; if (bus.instr_pc !== 32'h4) begin n_err++; $display("FAIL bh_held_pc got %h want 4", bus.instr_pc); end
        n_vec++; if (bus.pc_write !== 1'b1) begin n_err++; $display("FAIL bh_write got %b want 1", bus.pc_write); end
        n_vec++; if (bus.pc_write_data !== 32'h100) begin n_err++; $display("FAIL bh_wdata got %h want 100", bus.pc_write_data); end
        n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL bh_inc got %b want 0", bus.pc_inc); end
        tick();
        apply(1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0);
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL bh_squash got %b want 0", bus.instr_valid); end
        n_vec++; if (bus.mem_addr !== 30'h40) begin n_err++; $display("FAIL bh_addr got %h want 40", bus.mem_addr); end
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.instr_pc !== 32'h100) begin n_err++; $display("FAIL bh_new_pc got %h want 100", bus.instr_pc); end
        n_vec++; if (bus.instr !== 32'h12345678) begin n_err++; $display("FAIL bh_new_instr got %h want 12345678", bus.instr); end
        tick();
    endtask

    task automatic test_branch_ack();
        apply(1'b1, 32'h200, 1'b1, 32'hbad0bad0, 1'b0);
        n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL ba_inc got %b want 0", bus.pc_inc); end
        n_vec++; if (bus.pc_write !== 1'b1) begin n_err++; $display("FAIL ba_write got %b want 1", bus.pc_write); end
        tick();
        apply(1'b0, 32'h0, 1'b1, 32'h0c0ffee0, 1'b0);
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL ba_discard got %b want 0", bus.instr_valid); end
        n_vec++; if (bus.mem_addr !== 30'h80) begin n_err++; $display("FAIL ba_addr got %h want 80", bus.mem_addr); end
        tick();
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.instr_pc !== 32'h200) begin n_err++; $display("FAIL ba_pc got %h want 200", bus.instr_pc); end
        n_vec++; if (bus.instr !== 32'h0c0ffee0) begin n_err++; $display("FAIL ba_instr got %h want 0c0ffee0", bus.instr); end
        tick();
    endtask

    task automatic test_misaligned();
        apply(1'b1, 32'h102, 1'b1, 32'h0, 1'b0);
        n_vec++; if (bus.pc_write !== 1'b0) begin n_err++; $display("FAIL ma_write got %b want 0", bus.pc_write); end
        n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL ma_inc got %b want 0", bus.pc_inc); end
        tick();
        apply(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        n_vec++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL ma_fault got %b want 1", bus.fault); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL ma_req got %b want 0", bus.mem_req); end
        n_vec++; if (bus.pc_inc !== 1'b0) begin n_err++; $display("FAIL ma_ack_inc got %b want 0", bus.pc_inc); end
        tick();
        apply(1'b1, 32'h300, 1'b1, 32'h0, 1'b0);
        n_vec++; if (bus.pc_write !== 1'b0) begin n_err++; $display("FAIL ma_br_write got %b want 0", bus.pc_write); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL ma_br_req got %b want 0", bus.mem_req); end
        n_vec++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL ma_sticky got %b want 1", bus.fault); end
        tick();
        reset = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        n_vec++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL ma_clear got %b want 0", bus.fault); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit          bv;
        for (int i = 0; i < 800; i++) begin
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0)
                reset = 1'b1;
            else
                reset = 1'b0;
            bv  = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            else                           tgt[1:0] = 2'b00;
            apply(bv, tgt, ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 2) == 0));
            n_vec++; if (bus.mem_req !== e_mem_req) begin n_err++; $display("FAIL rnd_req cyc %0d got %b want %b", i, bus.mem_req, e_mem_req); end
            n_vec++; if (bus.pc_inc !== e_pc_inc) begin n_err++; $display("FAIL rnd_inc cyc %0d got %b want %b", i, bus.pc_inc, e_pc_inc); end
            n_vec++; if (bus.pc_write !== e_pc_write) begin n_err++; $display("FAIL rnd_write cyc %0d got %b want %b", i, bus.pc_write, e_pc_write); end
            n_vec++; if (bus.instr_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.instr_valid, m_valid); end
            n_vec++; if (bus.fault !== m_fault) begin n_err++; $display("FAIL rnd_fault cyc %0d got %b want %b", i, bus.fault, m_fault); end
            if (e_pc_write) begin
                n_vec++; if (bus.pc_write_data !== tgt) begin n_err++; $display("FAIL rnd_wdata cyc %0d got %h want %h", i, bus.pc_write_data, tgt); end
            end
            if (e_mem_req) begin
                n_vec++; if (bus.mem_addr !== pc[31:2]) begin n_err++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, bus.mem_addr, pc[31:2]); end
            end
            if (m_valid) begin
                n_vec++; if (bus.instr !== m_instr) begin n_err++; $display("FAIL rnd_instr cyc %0d got %h want %h", i, bus.instr, m_instr); end
                n_vec++; if (bus.instr_pc !== m_ipc) begin n_err++; $display("FAIL rnd_ipc cyc %0d got %h want %h", i, bus.instr_pc, m_ipc); end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        bus.pc_read_data  = 32'h0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = 32'h0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 32'h0;
        bus.stall         = 1'b0;
        test_reset();
        test_straight_line();
        test_wait_stall();
        test_branch_hold();
        test_branch_ack();
        test_misaligned();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
